// File: rtl/sw_req_pkg.sv
// Shared types for the green-request switch conditioner: channel FSM encoding
// and channel index constants.
package sw_req_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } ch_state_e;

    localparam int CH1 = 0;
    localparam int CH2 = 1;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus counter debouncer for one raw switch; also emits a
// one-cycle pulse on the cycle the debounced level rises.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic db_o,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // stage p0/p1: metastability guard on the asynchronous switch pin
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= sw_i;
            sync_p1 <= sync_p0;
        end
    end

    // debounce stage: any agreeing cycle restarts the stability count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            db_o   <= 1'b0;
            rise_o <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            if (sync_p1 != db_o) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt    <= '0;
                    db_o   <= sync_p1;
                    rise_o <= sync_p1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sw_green_request.sv
// Green-request conditioner: debounced switches latch one pending request per
// direction until acked. Optional request lifetime under SW_REQ_TIMEOUT_EN.
module sw_green_request
    import sw_req_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_green_1,
    input  logic sw_green_2,
    input  logic ack1_i,
    input  logic ack2_i,
    output logic req1_o,
    output logic req2_o,
    output logic first_o,
    output logic expired1_o,
    output logic expired2_o
);

    logic [1:0] db;
    logic [1:0] rise;
    logic [1:0] ack;
    logic [1:0] enter;
    logic [1:0] tmo_hit;
    logic [1:0] req;
    logic       first_nx;
    ch_state_e  st    [2];
    ch_state_e  st_nx [2];

    assign ack = {ack2_i, ack1_i};

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sw_i   (sw_green_1),
        .db_o   (db[CH1]),
        .rise_o (rise[CH1])
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sw_i   (sw_green_2),
        .db_o   (db[CH2]),
        .rise_o (rise[CH2])
    );

    // A served request parks in HOLD while the switch is still pressed, so one
    // press can never raise two requests.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            st_nx[c] = st[c];
            enter[c] = 1'b0;
            case (st[c])
                IDLE: if (rise[c]) begin
                    st_nx[c] = PEND;
                    enter[c] = 1'b1;
                end
                PEND: if (ack[c] || tmo_hit[c]) st_nx[c] = db[c] ? HOLD : IDLE;
                HOLD: if (!db[c]) st_nx[c] = IDLE;
                default: st_nx[c] = IDLE;
            endcase
        end
    end

    // Simultaneous entries alternate the winner so neither direction starves.
    always_comb begin
        first_nx = first_o;
        if (enter[CH1] && enter[CH2])
            first_nx = ~first_o;
        else if (enter[CH1] && st[CH2] != PEND)
            first_nx = 1'b0;
        else if (enter[CH2] && st[CH1] != PEND)
            first_nx = 1'b1;
    end

    // fsm stage: state, request level and arrival order
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st[CH1] <= IDLE;
            st[CH2] <= IDLE;
            req     <= '0;
            first_o <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                st[c]  <= st_nx[c];
                req[c] <= (st_nx[c] == PEND);
            end
            first_o <= first_nx;
        end
    end

    assign req1_o = req[CH1];
    assign req2_o = req[CH2];

`ifdef SW_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt [2];
    logic [1:0]    expired;

    always_comb begin
        tmo_hit = '0;
        for (int c = 0; c < 2; c++)
            tmo_hit[c] = (st[c] == PEND) && (tcnt[c] == TW'(TIMEOUT_CYCLES - 1));
    end

    // lifetime stage: an ack arriving on the expiry cycle suppresses the pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tcnt[CH1] <= '0;
            tcnt[CH2] <= '0;
            expired   <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                expired[c] <= tmo_hit[c] && !ack[c];
                if (enter[c])
                    tcnt[c] <= '0;
                else if (st[c] == PEND)
                    tcnt[c] <= tcnt[c] + 1'b1;
            end
        end
    end

    assign expired1_o = expired[CH1];
    assign expired2_o = expired[CH2];
`else
    assign tmo_hit    = '0;
    assign expired1_o = 1'b0;
    assign expired2_o = 1'b0;
`endif

endmodule

// File: tb/tb_sw_green_request.sv
// Bench for sw_green_request: directed scenarios plus random switch/ack traffic,
// checked every cycle against a behavioural request model.
module tb_sw_green_request;

    localparam int D = 4;
    localparam int T = 20;
`ifdef SW_REQ_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw1 = 1'b0, sw2 = 1'b0, ack1 = 1'b0, ack2 = 1'b0;
    logic req1, req2, first, exp1, exp2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sw_green_request #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sw_green_1 (sw1),
        .sw_green_2 (sw2),
        .ack1_i     (ack1),
        .ack2_i     (ack2),
        .req1_o     (req1),
        .req2_o     (req2),
        .first_o    (first),
        .expired1_o (exp1),
        .expired2_o (exp2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw pins delayed two samples, a level that flips once D
    // consecutive samples disagree with it, and a pending flag per direction
    // raised one cycle after a rising level and dropped by ack or lifetime.
    bit m_sync [2][2];
    bit m_hist [2][D];
    int m_nhist [2];
    bit m_db [2];
    bit m_rise [2];
    bit m_pend [2];
    int m_age [2];
    bit m_exp [2];
    bit m_first;
    bit m_ent [2];
    bit m_oldp [2];
    bit m_raw [2];
    bit m_ack [2];
    bit m_smp, m_all;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_sync[c][0] = 0; m_sync[c][1] = 0; m_nhist[c] = 0;
                m_db[c] = 0; m_rise[c] = 0; m_pend[c] = 0; m_age[c] = 0; m_exp[c] = 0;
            end
            m_first = 0;
        end else begin
            m_raw[0] = sw1;  m_raw[1] = sw2;
            m_ack[0] = ack1; m_ack[1] = ack2;
            for (int c = 0; c < 2; c++) begin
                m_oldp[c] = m_pend[c];
                m_ent[c] = 0;
                m_exp[c] = 0;
                if (!m_pend[c]) begin
                    if (m_rise[c]) begin
                        m_pend[c] = 1; m_age[c] = 0; m_ent[c] = 1;
                    end
                end else begin
                    m_age[c]++;
                    if (m_ack[c]) m_pend[c] = 0;
                    else if (TMO && m_age[c] == T) begin
                        m_pend[c] = 0; m_exp[c] = 1;
                    end
                end
                m_smp = m_sync[c][1];
                m_sync[c][1] = m_sync[c][0];
                m_sync[c][0] = m_raw[c];
                for (int i = D - 1; i > 0; i--) m_hist[c][i] = m_hist[c][i-1];
                m_hist[c][0] = m_smp;
                if (m_nhist[c] < D) m_nhist[c]++;
                m_all = (m_nhist[c] == D);
                for (int i = 0; i < D; i++) if (m_hist[c][i] == m_db[c]) m_all = 0;
                m_rise[c] = 0;
                if (m_all) begin
                    m_db[c] = ~m_db[c];
                    m_nhist[c] = 0;
                    m_rise[c] = m_db[c];
                end
            end
            if (m_ent[0] && m_ent[1]) m_first = ~m_first;
            else if (m_ent[0] && !m_oldp[1]) m_first = 0;
            else if (m_ent[1] && !m_oldp[0]) m_first = 1;
        end
    end

    always @(negedge clk) begin
        check("req1",  int'(req1),  int'(m_pend[0]));
        check("req2",  int'(req2),  int'(m_pend[1]));
        check("first", int'(first), int'(m_first));
        check("exp1",  int'(exp1),  int'(m_exp[0]));
        check("exp2",  int'(exp2),  int'(m_exp[1]));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Ticks until the chosen request is seen high; gives up after lim ticks.
    task automatic wait_req(input int ch, input int lim, output int lat);
        lat = 0;
        while (((ch == 0) ? req1 : req2) !== 1'b1 && lat < lim) begin
            tick(1);
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lat, n, pulses, hi2, hold1, hold2;

    initial begin
        tick(3);
        check("rst_req1", int'(req1), 0);
        check("rst_req2", int'(req2), 0);
        check("rst_first", int'(first), 0);
        rst = 1'b0;
        tick(2);

        // clean press: visible D+2 edges after the sampling edge
        sw1 = 1; tick(1);
        wait_req(0, 50, lat);
        check("press_latency", lat, 6);
        tick(5);
        ack1 = 1; tick(1); ack1 = 0;
        check("ack_clears", int'(req1), 0);
        tick(20);
        check("held_no_rerequest", int'(req1), 0);
        sw1 = 0; tick(D + 4);

        // release before ack: request survives, then a fresh press works
        sw1 = 1; tick(1);
        wait_req(0, 50, lat);
        check("second_press_latency", lat, 6);
        sw1 = 0; tick(10);
        check("release_keeps_req", int'(req1), 1);
        ack1 = 1; tick(1); ack1 = 0;
        check("ack_after_release", int'(req1), 0);
        tick(D + 4);
        sw1 = 1; tick(1);
        wait_req(0, 50, lat);
        check("idle_after_release", lat, 6);
        ack1 = 1; tick(1); ack1 = 0; sw1 = 0; tick(D + 4);

        // bounce: toggle every 2 cycles for 20 cycles, then settle low
        hi2 = 0;
        for (int i = 0; i < 10; i++) begin
            sw2 = ~sw2; tick(2);
            if (req2) hi2 = 1;
        end
        sw2 = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (req2) hi2 = 1;
        end
        check("bounce_no_req", hi2, 0);
        check("bounce_db_low", int'(dut.u_db2.db_o), 0);

        // ordering: ch2 first, then ch1 ten cycles later
        sw2 = 1; tick(1);
        wait_req(1, 50, lat);
        tick(3);
        sw1 = 1; tick(1);
        wait_req(0, 50, lat);
        check("order_first_ch2", int'(first), 1);
        ack1 = 1; ack2 = 1; tick(1); ack1 = 0; ack2 = 0;
        sw1 = 0; sw2 = 0; tick(D + 4);
        sw1 = 1; sw2 = 1; tick(1);
        wait_req(0, 50, lat);
        check("both_req2", int'(req2), 1);
        check("both_toggle_first", int'(first), 0);
        ack1 = 1; ack2 = 1; tick(1); ack1 = 0; ack2 = 0;
        sw1 = 0; sw2 = 0; tick(D + 4);

        // reset mid-PEND clears outputs asynchronously
        sw2 = 1; tick(1);
        wait_req(1, 50, lat);
        sw1 = 1; tick(1);
        wait_req(0, 50, lat);
        check("pre_reset_first", int'(first), 1);
        @(posedge clk); #3;
        rst = 1; #1;
        check("async_rst_req1", int'(req1), 0);
        check("async_rst_req2", int'(req2), 0);
        check("async_rst_first", int'(first), 0);
        check("async_rst_exp", int'(exp1 | exp2), 0);
        sw1 = 0; sw2 = 0;
        tick(2);
        rst = 0;
        tick(2);

        // lifetime behaviour
        sw1 = 1; tick(1);
        wait_req(0, 50, lat);
        if (TMO) begin
            n = 0; pulses = 0;
            while (req1 && n < 100) begin
                tick(1); n++;
                if (exp1) pulses++;
            end
            tick(1);
            if (exp1) pulses++;
            check("timeout_len", n, 20);
            check("timeout_pulses", pulses, 1);
            sw1 = 0; tick(D + 4);
            sw1 = 1; tick(1);
            wait_req(0, 50, lat);
            tick(19);
            ack1 = 1; tick(1); ack1 = 0;
            check("ack_on_expiry_req", int'(req1), 0);
            check("ack_on_expiry_pulse", int'(exp1), 0);
        end else begin
            tick(110);
            check("no_timeout_req", int'(req1), 1);
            check("no_timeout_exp", int'(exp1), 0);
            ack1 = 1; tick(1); ack1 = 0;
            check("late_ack_clears", int'(req1), 0);
        end
        sw1 = 0; tick(D + 4);

        // random traffic, including sub-threshold bounces and stray acks
        hold1 = 1; hold2 = 1;
        for (int i = 0; i < 3000; i++) begin
            if (--hold1 == 0) begin sw1 = ~sw1; hold1 = $urandom_range(1, 12); end
            if (--hold2 == 0) begin sw2 = ~sw2; hold2 = $urandom_range(1, 12); end
            ack1 = ($urandom_range(0, 7) == 0);
            ack2 = ($urandom_range(0, 7) == 0);
            tick(1);
        end
        ack1 = 0; ack2 = 0; sw1 = 0; sw2 = 0;
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
